// File: rtl/button_array_ctl_if.sv
// button_array_ctl_if: groups the mouse, mask, VGA and click/hover signals of
// button_array_ctl so the controller can be dropped into a pipeline as one port.
//   master : driver side (mouse/VGA source, game FSM) - drives the inputs
//   slave  : button_array_ctl side - drives pressed_*, hover_* and vga_out
// Parameters: N = COLS*ROWS (mask width), IDX_W = index width.
// Optional feature macro used by the controller: BUTTON_ARRAY_HOVER_EN.

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`define VGA_VCOUNT(b) b[37:27]
`define VGA_VSYNC(b) b[26]
`define VGA_VBLNK(b) b[25]
`define VGA_HCOUNT(b) b[24:14]
`define VGA_HSYNC(b) b[13]
`define VGA_HBLNK(b) b[12]
`define VGA_RGB(b) b[11:0]
`endif

interface button_array_ctl_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 4
);
    logic                     enable;
    logic                     mouse_left;
    logic [11:0]              mouse_xpos;
    logic [11:0]              mouse_ypos;
    logic [N-1:0]             button_mask;
    logic [`VGA_BUS_SIZE-1:0] vga_in;
    logic                     pressed_valid;
    logic [IDX_W-1:0]         pressed_idx;
    logic                     hover_valid;
    logic [IDX_W-1:0]         hover_idx;
    logic [`VGA_BUS_SIZE-1:0] vga_out;

    modport master (
        output enable, mouse_left, mouse_xpos, mouse_ypos, button_mask, vga_in,
        input  pressed_valid, pressed_idx, hover_valid, hover_idx, vga_out
    );

    modport slave (
        input  enable, mouse_left, mouse_xpos, mouse_ypos, button_mask, vga_in,
        output pressed_valid, pressed_idx, hover_valid, hover_idx, vga_out
    );
endinterface

// File: rtl/button_array_ctl.sv
// button_array_ctl: COLS x ROWS grid of on-screen buttons for the memory game.
// Hit-tests the mouse, reports a completed click (press and release on the same
// live button) as pressed_idx plus a one-cycle pressed_valid strobe, and
// overlays the buttons (fill, 1-pixel border, hover/press shading) on the VGA
// stream with a fixed 1-clock latency.
// Ports:
//   clk  - pixel clock
//   rst  - synchronous active-low reset
//   bus  - button_array_ctl_if.slave: enable, mouse_left, mouse_xpos/ypos,
//          button_mask, vga_in in; pressed_valid/idx, hover_valid/idx, vga_out out
// Configuration: define BUTTON_ARRAY_HOVER_EN to enable hover shading and the
// hover_valid/hover_idx outputs; otherwise those outputs are tied to 0.

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`define VGA_VCOUNT(b) b[37:27]
`define VGA_VSYNC(b) b[26]
`define VGA_VBLNK(b) b[25]
`define VGA_HCOUNT(b) b[24:14]
`define VGA_HSYNC(b) b[13]
`define VGA_HBLNK(b) b[12]
`define VGA_RGB(b) b[11:0]
`endif

module button_array_ctl #(
    parameter int unsigned X_POS      = 64,
    parameter int unsigned Y_POS      = 96,
    parameter int unsigned COLS       = 4,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned WIDTH      = 96,
    parameter int unsigned HEIGHT     = 96,
    parameter int unsigned GAP        = 16,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned LOCKOUT    = 1000,
    parameter logic [11:0] FILL_RGB   = 12'h48C,
    parameter logic [11:0] HOVER_RGB  = 12'h6AF,
    parameter logic [11:0] PRESS_RGB  = 12'h246,
    parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
    input logic              clk,
    input logic              rst,
    button_array_ctl_if.slave bus
);
    localparam int unsigned N     = COLS * ROWS;
    // counter only ever holds LOCKOUT-1 down to 0
    localparam int unsigned CNT_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, FIRE, LOCK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] arm_idx;
    logic             left_q;
    logic             pressed_valid_q;
    logic [IDX_W-1:0] pressed_idx_q;
    logic [`VGA_BUS_SIZE-1:0] vga_q;

    logic [11:0]  pix_x, pix_y;
    logic [N-1:0] mouse_in, pix_in, pix_edge;

    assign pix_x = {1'b0, `VGA_HCOUNT(bus.vga_in)};
    assign pix_y = {1'b0, `VGA_VCOUNT(bus.vga_in)};

    // Per-button rectangle bounds are elaboration constants.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned I  = r * COLS + c;
            localparam logic [11:0] XL = 12'(X_POS + c * (WIDTH + GAP));
            localparam logic [11:0] XH = 12'(X_POS + c * (WIDTH + GAP) + WIDTH - 1);
            localparam logic [11:0] YL = 12'(Y_POS + r * (HEIGHT + GAP));
            localparam logic [11:0] YH = 12'(Y_POS + r * (HEIGHT + GAP) + HEIGHT - 1);

            assign mouse_in[I] = (bus.mouse_xpos >= XL) && (bus.mouse_xpos <= XH) &&
                                 (bus.mouse_ypos >= YL) && (bus.mouse_ypos <= YH);
            assign pix_in[I]   = (pix_x >= XL) && (pix_x <= XH) &&
                                 (pix_y >= YL) && (pix_y <= YH);
            assign pix_edge[I] = (pix_x == XL) || (pix_x == XH) ||
                                 (pix_y == YL) || (pix_y == YH);
        end
    end

    // Priority encoders over live buttons; scanning downward lets the lowest index win.
    logic             mouse_hit, pix_hit, pix_border;
    logic [IDX_W-1:0] mouse_idx, pix_idx;

    always_comb begin
        mouse_hit  = 1'b0;
        mouse_idx  = '0;
        pix_hit    = 1'b0;
        pix_idx    = '0;
        pix_border = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (mouse_in[i-1] && !bus.button_mask[i-1]) begin
                mouse_hit = 1'b1;
                mouse_idx = IDX_W'(i - 1);
            end
            if (pix_in[i-1] && !bus.button_mask[i-1]) begin
                pix_hit    = 1'b1;
                pix_idx    = IDX_W'(i - 1);
                pix_border = pix_edge[i-1];
            end
        end
    end

    logic arm_masked;
    assign arm_masked = |(bus.button_mask & (N'(1) << arm_idx));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            arm_idx         <= '0;
            left_q          <= 1'b1;
            pressed_valid_q <= 1'b0;
            pressed_idx_q   <= '0;
        end else begin
            left_q          <= bus.mouse_left;
            pressed_valid_q <= 1'b0;
            if (!bus.enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.mouse_left && !left_q && mouse_hit) begin
                            state   <= ARMED;
                            arm_idx <= mouse_idx;
                        end
                    end
                    ARMED: begin
                        if (arm_masked) begin
                            state <= IDLE;
                        end else if (!bus.mouse_left) begin
                            // strobe is registered on entry so it is visible during FIRE
                            if (mouse_hit && (mouse_idx == arm_idx)) begin
                                state           <= FIRE;
                                pressed_valid_q <= 1'b1;
                                pressed_idx_q   <= arm_idx;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    FIRE: begin
                        cnt   <= CNT_W'(LOCKOUT - 1);
                        state <= LOCK;
                    end
                    LOCK: begin
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BUTTON_ARRAY_HOVER_EN
    logic             hover_valid_q;
    logic [IDX_W-1:0] hover_idx_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hover_valid_q <= 1'b0;
            hover_idx_q   <= '0;
        end else begin
            hover_valid_q <= bus.enable && mouse_hit;
            hover_idx_q   <= (bus.enable && mouse_hit) ? mouse_idx : '0;
        end
    end

    assign bus.hover_valid = hover_valid_q;
    assign bus.hover_idx   = hover_idx_q;
`else
    assign bus.hover_valid = 1'b0;
    assign bus.hover_idx   = '0;
`endif

    logic [`VGA_BUS_SIZE-1:0] vga_next;

    always_comb begin
        vga_next = bus.vga_in;
        if (bus.enable && pix_hit && !`VGA_HBLNK(bus.vga_in) && !`VGA_VBLNK(bus.vga_in)) begin
            if (pix_border)
                `VGA_RGB(vga_next) = BORDER_RGB;
            else if ((state == ARMED) && (arm_idx == pix_idx))
                `VGA_RGB(vga_next) = PRESS_RGB;
`ifdef BUTTON_ARRAY_HOVER_EN
            else if (hover_valid_q && (hover_idx_q == pix_idx))
                `VGA_RGB(vga_next) = HOVER_RGB;
`endif
            else
                `VGA_RGB(vga_next) = FILL_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) vga_q <= '0;
        else      vga_q <= vga_next;
    end

    assign bus.pressed_valid = pressed_valid_q;
    assign bus.pressed_idx   = pressed_idx_q;
    assign bus.vga_out       = vga_q;

endmodule

// File: doc/button_array_ctl.md
# button_array_ctl

Parametrised grid of clickable on-screen buttons for the memory game, and successor of the single-button controller. It hit-tests the mouse against COLS×ROWS rectangles and reports a completed click (press and release on the same live button) as an index plus a one-cycle strobe. It also overlays the buttons onto the VGA stream with per-button fill, border and hover/press shading. It sits in the VGA pipeline after the background stage and feeds the game-logic FSM, which masks off matched cards through `button_mask`.

## Interface
- `X_POS`, 64: left edge of button (0,0), pixels
- `Y_POS`, 96: top edge of button (0,0), pixels
- `COLS`, 4: buttons per row
- `ROWS`, 2: button rows
- `WIDTH`, 96: button width, pixels
- `HEIGHT`, 96: button height, pixels
- `GAP`, 16: spacing between adjacent buttons, pixels
- `IDX_W`, 4: index width; COLS*ROWS ≤ 2**IDX_W is required
- `LOCKOUT`, 1000: cycles during which clicks are ignored after a reported click (≥1)
- `FILL_RGB`, 12'h48C / `HOVER_RGB`, 12'h6AF / `PRESS_RGB`, 12'h246 / `BORDER_RGB`, 12'hFFF: colours
- `clk` in 1: pixel clock, the single clock
- `rst` in 1: reset, synchronous, active-low
- `enable` in 1: block active; when low, nothing is drawn and no click is accepted
- `mouse_left` in 1: left mouse button level, already synchronous to `clk`
- `mouse_xpos`, `mouse_ypos` in 12: cursor position
- `button_mask` in COLS*ROWS: bit i=1 means button i is hidden and not clickable
- `vga_in` in `VGA_BUS_SIZE`: VGA bus; fields are accessed through the codebase VGA macros
- `pressed_valid` out 1: one-cycle strobe marking a completed click
- `pressed_idx` out IDX_W: index of the clicked button, held until the next strobe
- `hover_idx` out IDX_W, `hover_valid` out 1: button currently under the cursor
- `vga_out` out `VGA_BUS_SIZE`: VGA bus with the overlay applied

## Operation
- Geometry: button i = r*COLS+c spans x ∈ [X_POS+c*(WIDTH+GAP), +WIDTH−1] and y ∈ [Y_POS+r*(HEIGHT+GAP), +HEIGHT−1], inclusive.
- All comparisons are 12-bit unsigned. Edge constants are computed at elaboration; no runtime multiply or divide.
- Mouse hit: combinational. "Live" means inside a button with its mask bit 0. If the regions overlapped, the lowest index would win; GAP ≥ 0 prevents overlap.
- `hover_valid`/`hover_idx` are registered copies of the mouse hit, gated by `enable`.
- Click FSM states: IDLE, ARMED, FIRE, LOCK.
  - IDLE → ARMED: on a `mouse_left` rising edge (registered previous level) while the hit is live. Latch `arm_idx`.
  - A rising edge off all buttons, or with the button already held when entering IDLE, is ignored.
  - ARMED: stay while `mouse_left`=1. On release, go to FIRE if the hit is live and equals `arm_idx`; otherwise go to IDLE.
  - ARMED → IDLE also occurs immediately if `button_mask[arm_idx]` becomes 1.
  - FIRE: `pressed_valid`=1 and `pressed_idx`←`arm_idx` for one cycle. Load the counter with LOCKOUT−1, then go to LOCK.
  - LOCK: decrement the counter; at 0, go to IDLE. Mouse activity in LOCK is discarded.
  - `enable`=0 in any state forces IDLE next cycle and clears the counter. A FIRE already in progress completes its strobe.
- Draw: for each pixel, use hcount/vcount from `vga_in` against the same geometry.
  - Pixel in a live button and not blanked: the 1-pixel perimeter gets BORDER_RGB.
  - Interior gets PRESS_RGB if the FSM is ARMED on that button; otherwise HOVER_RGB if it is the hover button; otherwise FILL_RGB.
  - Pixels outside all live buttons, or during blanking, pass the `vga_in` rgb through unchanged.

## Timing
- `vga_out` = `vga_in` delayed exactly 1 clock; every field is registered and all fields stay aligned.
- Click latency: release sampled on cycle n → `pressed_valid` high on cycle n+1.
- A new click can be armed no earlier than LOCKOUT+1 cycles after the `pressed_valid` strobe.
- Reset (`rst`=0 on a clock edge) gives FSM=IDLE, counter=0, `pressed_valid`=0, `pressed_idx`=0, `hover_valid`=0, `hover_idx`=0, `vga_out`=0, and the previous `mouse_left` register =1. The last value prevents a false rising edge if the button is held through reset.
- Reset in ARMED or LOCK aborts the operation; no strobe is produced.

## Configuration
- `BUTTON_ARRAY_HOVER_EN` defined: hover shading and the `hover_valid`/`hover_idx` outputs behave as described above.
- Undefined: interiors use only FILL_RGB/PRESS_RGB; `hover_valid`/`hover_idx` are tied to 0; the hover registers are not synthesised.

## Test plan
- Defaults, mask=0. Move to (180,210), press, release 10 cycles later → one `pressed_valid` pulse with `pressed_idx`=5, on the cycle after release.
- Press at (180,210), drag to (300,210) (button 6), release → no strobe; FSM back in IDLE.
- Set `button_mask`[5]=1. Click at (180,210) → no strobe. Pixel (200,250) on `vga_out` equals the `vga_in` rgb, delayed 1 cycle.
- LOCKOUT=20. Click button 0 at (70,100), then click again 5 cycles after the strobe → only one strobe. A click started 25 cycles after the strobe → second strobe with idx 0.
- Hold `mouse_left` through reset release, then release it → no strobe. Pulse `rst` low while ARMED → no strobe and all outputs 0.
- Frame scan with the cursor on button 2: pixel (288,96) = BORDER_RGB; interior (300,120) = HOVER_RGB (FILL_RGB with `BUTTON_ARRAY_HOVER_EN` undefined); gap pixel (170,120) passes through.
